// File: rtl/johnson_pkg.sv
// Shared types and Johnson-code helpers for the phase monitor.
// Helpers take the counter width as an argument so one package serves any N up to JC_MAX_N.
package johnson_pkg;

    localparam int unsigned JC_MAX_N = 16;
    localparam int unsigned JC_IDX_W = 5;

    typedef enum logic [1:0] {
        SYNC,
        LOCKED,
        RECOVER
    } mon_state_t;

    typedef struct packed {
        logic                legal;
        logic [JC_IDX_W-1:0] idx;
    } jc_dec_t;

    // Phase k<=n: top k bits set; phase n+k: top k bits clear, rest set.
    function automatic jc_dec_t jc_decode(input logic [JC_MAX_N-1:0] code, input int unsigned n);
        jc_dec_t             r;
        logic [JC_MAX_N-1:0] pat;
        r = '0;
        for (int unsigned k = 0; k < 2 * n; k++) begin
            pat = '0;
            for (int unsigned b = 0; b < n; b++) begin
                if (k <= n)
                    pat[b] = (b >= n - k);
                else
                    pat[b] = (b < n - (k - n));
            end
            if (code == pat) begin
                r.legal = 1'b1;
                r.idx   = JC_IDX_W'(k);
            end
        end
        return r;
    endfunction

    function automatic logic [JC_IDX_W-1:0] jc_succ(input logic [JC_IDX_W-1:0] idx, input int unsigned n);
        if (32'(idx) == 2 * n - 1)
            return '0;
        return idx + 1'b1;
    endfunction

endpackage

// File: rtl/johnson_phase_monitor_if.sv
// Counter-sample input and decoded/status outputs of the Johnson phase monitor.
interface johnson_phase_monitor_if #(
    parameter int unsigned N = 4
);
    localparam int unsigned IDX_W = $clog2(2 * N);

    logic [N-1:0]     jc_in;
    logic [IDX_W-1:0] phase_idx;
    logic [2*N-1:0]   phase_oh;
    logic             phase_vld;
    logic             seq_err;
    logic             locked;
    logic [N-1:0]     fix_rst_n;
    logic [7:0]       err_cnt;

    modport master (
        input  jc_in,
        output phase_idx, phase_oh, phase_vld, seq_err, locked, fix_rst_n, err_cnt
    );

    modport slave (
        output jc_in,
        input  phase_idx, phase_oh, phase_vld, seq_err, locked, fix_rst_n, err_cnt
    );

endinterface

// File: rtl/johnson_decode.sv
// Combinational Johnson code to {legal, phase index, one-hot phase}.
module johnson_decode
    import johnson_pkg::*;
#(
    parameter  int unsigned N     = 4,
    localparam int unsigned IDX_W = $clog2(2 * N)
) (
    input  logic [N-1:0]     code,
    output logic             legal,
    output logic [IDX_W-1:0] idx,
    output logic [2*N-1:0]   onehot
);

    logic [JC_MAX_N-1:0] code_ext;
    jc_dec_t             dec;

    always_comb begin
        code_ext         = '0;
        code_ext[N-1:0]  = code;
        dec              = jc_decode(code_ext, N);
        legal            = dec.legal;
        idx              = IDX_W'(dec.idx);
        onehot           = '0;
        if (dec.legal)
            onehot[idx] = 1'b1;
    end

endmodule

// File: rtl/johnson_phase_monitor.sv
// Registers decoded Johnson counter phase, checks step order, tracks lock and
// pulses the counter's per-FF resets after persistent faults while locked.
module johnson_phase_monitor
    import johnson_pkg::*;
#(
    parameter int unsigned N         = 4,
    parameter int unsigned LOCK_CNT  = 3,
    parameter int unsigned ERR_LIMIT = 2,
    parameter int unsigned RECOV_CYC = 2
) (
    input logic                     clk,
    input logic                     rst,
    johnson_phase_monitor_if.master mon
);

    localparam int unsigned IDX_W  = $clog2(2 * N);
    localparam logic [3:0]  LOCK_C = 4'(LOCK_CNT);
    localparam logic [3:0]  ERR_C  = 4'(ERR_LIMIT);
    localparam logic [3:0]  REC_C  = 4'(RECOV_CYC);

    logic             dec_legal;
    logic [IDX_W-1:0] dec_idx;
    logic [2*N-1:0]   dec_oh;

    mon_state_t       state;
    logic [IDX_W-1:0] prev_idx;
    logic             prev_vld;
    logic [3:0]       step_cnt;
    logic [3:0]       bad_cnt;
    logic [3:0]       rec_cnt;

    logic [IDX_W-1:0] succ_idx;
    logic             seq_bad;
    logic             good;

    johnson_decode #(.N(N)) u_decode (
        .code   (mon.jc_in),
        .legal  (dec_legal),
        .idx    (dec_idx),
        .onehot (dec_oh)
    );

    always_comb begin
        succ_idx = IDX_W'(jc_succ(JC_IDX_W'(prev_idx), N));
        seq_bad  = dec_legal & prev_vld & (dec_idx != succ_idx);
        good     = dec_legal & ~seq_bad;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= SYNC;
            prev_idx      <= '0;
            prev_vld      <= 1'b0;
            step_cnt      <= '0;
            bad_cnt       <= '0;
            rec_cnt       <= '0;
            mon.phase_idx <= '0;
            mon.phase_oh  <= '0;
            mon.phase_vld <= 1'b0;
            mon.seq_err   <= 1'b0;
            mon.locked    <= 1'b0;
            mon.fix_rst_n <= '1;
            mon.err_cnt   <= '0;
        end else begin
            mon.phase_vld <= dec_legal;
            mon.phase_oh  <= dec_oh;
            if (dec_legal)
                mon.phase_idx <= dec_idx;

            case (state)
                SYNC: begin
                    mon.seq_err <= seq_bad;
                    prev_vld    <= dec_legal;
                    if (dec_legal)
                        prev_idx <= dec_idx;
                    if (!good) begin
                        step_cnt <= '0;
                    end else if (step_cnt == LOCK_C - 4'd1) begin
                        state      <= LOCKED;
                        mon.locked <= 1'b1;
                        step_cnt   <= '0;
                        bad_cnt    <= '0;
                    end else begin
                        step_cnt <= step_cnt + 4'd1;
                    end
                end
                LOCKED: begin
                    mon.seq_err <= seq_bad;
                    prev_vld    <= dec_legal;
                    if (dec_legal)
                        prev_idx <= dec_idx;
                    if (good) begin
                        bad_cnt <= '0;
                    end else if (bad_cnt == ERR_C - 4'd1) begin
                        // Recovery starts on this edge; rec_cnt counts the low cycles of fix_rst_n.
                        state         <= RECOVER;
                        mon.locked    <= 1'b0;
                        mon.fix_rst_n <= '0;
                        rec_cnt       <= 4'd1;
                        bad_cnt       <= '0;
                        if (mon.err_cnt != 8'hFF)
                            mon.err_cnt <= mon.err_cnt + 8'd1;
                    end else begin
                        bad_cnt <= bad_cnt + 4'd1;
                    end
                end
                RECOVER: begin
                    mon.seq_err <= 1'b0;
                    if (rec_cnt == REC_C) begin
                        state         <= SYNC;
                        mon.fix_rst_n <= '1;
                        step_cnt      <= '0;
                        bad_cnt       <= '0;
                        prev_vld      <= 1'b0;
                    end else begin
                        rec_cnt <= rec_cnt + 4'd1;
                    end
                end
                default: state <= SYNC;
            endcase
        end
    end

endmodule
